// File: rtl/fb_stream_arbiter.sv
// fb_stream_arbiter: frame-granular two-source arbiter feeding the framebuffer write stream
module fb_stream_arbiter #(
  parameter int DW           = 31,
  parameter int FRAME_PIXELS = 307200,
  parameter int TIMEOUT      = 1024,
  parameter int CW           = 19
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          s0_start,
  input  logic          s0_dv,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_start,
  input  logic          s1_dv,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  output logic          fb_st_start,
  output logic          fb_st_dv,
  output logic [DW-1:0] fb_st_data,
  input  logic          fb_st_ready,
  output logic [1:0]    grant,
  output logic          frame_done,
  output logic          frame_abort
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        r_state;
  logic          r_last;
  logic [CW-1:0] r_pix_cnt;
  logic [TW-1:0] r_idle_cnt;
  logic          w_idle, w_own0, w_own1, w_slot, w_acc, w_start, w_req0, w_req1, w_eof;
  logic [DW-1:0] w_data;
  logic [CW-1:0] w_cnt_next;
  assign w_idle     = r_state == IDLE;
  assign w_own0     = r_state == OWN0;
  assign w_own1     = r_state == OWN1;
  assign w_slot     = ~fb_st_dv | fb_st_ready;
  assign w_req0     = s0_dv & s0_start;
  assign w_req1     = s1_dv & s1_start;
  assign s0_ready   = w_idle ? s0_dv & ~s0_start : w_own0 & w_slot;
  assign s1_ready   = w_idle ? s1_dv & ~s1_start : w_own1 & w_slot;
  assign w_acc      = ((w_own0 & s0_dv) | (w_own1 & s1_dv)) & w_slot;
  assign w_start    = w_own1 ? s1_start : s0_start;
  assign w_data     = w_own1 ? s1_data : s0_data;
  assign w_cnt_next = w_start ? CW'(1) : r_pix_cnt + CW'(1);
  assign w_eof      = w_cnt_next == CW'(FRAME_PIXELS);
  assign grant      = {w_own1, w_own0};
  // ownership FSM: grant on start request, release on frame end or stall timeout
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_pix_cnt   <= '0;
      r_idle_cnt  <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (w_idle) begin
        r_pix_cnt  <= '0;
        r_idle_cnt <= '0;
        if (w_req0 && (!w_req1 || r_last)) r_state <= OWN0;
        else if (w_req1) r_state <= OWN1;
      end else if (w_acc) begin
        r_idle_cnt <= '0;
        if (w_eof) begin
          r_state    <= IDLE;
          r_last     <= w_own1;
          r_pix_cnt  <= '0;
          frame_done <= 1'b1;
        end else r_pix_cnt <= w_cnt_next;
      end else if (r_idle_cnt == TW'(TIMEOUT - 1)) begin
        r_state     <= IDLE;
        r_last      <= w_own1;
        r_pix_cnt   <= '0;
        r_idle_cnt  <= '0;
        frame_abort <= 1'b1;
      end else r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  // output register: load on accept, drain when the sink takes it, hold while stalled
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) {fb_st_start, fb_st_dv, fb_st_data} <= '0;
    else if (w_acc) {fb_st_start, fb_st_dv, fb_st_data} <= {w_start, 1'b1, w_data};
    else if (fb_st_ready) begin
      fb_st_start <= 1'b0;
      fb_st_dv    <= 1'b0;
    end
endmodule

// File: tb/tb_fb_stream_arbiter.sv
// tb_fb_stream_arbiter: directed scenarios plus randomized run against a frame-level reference model
module tb_fb_stream_arbiter;
  localparam int DW = 16, FP = 4, TO = 8, CW = 8;
  logic clk_clk = 1'b0, reset_reset_n = 1'b0;
  logic s0_start = 1'b0, s0_dv = 1'b0, s1_start = 1'b0, s1_dv = 1'b0, fb_st_ready = 1'b1;
  logic [DW-1:0] s0_data = '0, s1_data = '0, fb_st_data;
  logic s0_ready, s1_ready, fb_st_start, fb_st_dv, frame_done, frame_abort;
  logic [1:0] grant;
  int n_chk = 0, n_pass = 0;

  fb_stream_arbiter #(.DW(DW), .FRAME_PIXELS(FP), .TIMEOUT(TO), .CW(CW)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .s0_start(s0_start), .s0_dv(s0_dv), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_start(s1_start), .s1_dv(s1_dv), .s1_data(s1_data), .s1_ready(s1_ready),
    .fb_st_start(fb_st_start), .fb_st_dv(fb_st_dv), .fb_st_data(fb_st_data), .fb_st_ready(fb_st_ready),
    .grant(grant), .frame_done(frame_done), .frame_abort(frame_abort));

  always #5 clk_clk = ~clk_clk;

  task automatic tick;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_reset;
    reset_reset_n = 1'b0;
    {s0_start, s0_dv, s0_data, s1_start, s1_dv, s1_data} = '0;
    fb_st_ready = 1'b1;
    tick;
    tick;
    reset_reset_n = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if ({fb_st_start, fb_st_dv, fb_st_data, grant, frame_done, frame_abort, s0_ready, s1_ready} !== '0)
      $display("FAIL reset_outputs got dv=%b grant=%b done=%b abort=%b exp all zero", fb_st_dv, grant, frame_done, frame_abort);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_single_frame;
    logic [DW-1:0] d[4];
    do_reset;
    for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
    s0_dv = 1'b1; s0_start = 1'b1; s0_data = d[0];
    #1;
    n_chk++; if (s0_ready !== 1'b0) $display("FAIL idle_start_held got=%b exp=0", s0_ready); else n_pass++;
    tick;
    n_chk++; if (grant !== 2'b01) $display("FAIL single_grant got=%b exp=01", grant); else n_pass++;
    n_chk++; if (fb_st_dv !== 1'b0) $display("FAIL single_lag got=%b exp=0", fb_st_dv); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_chk++; if ({fb_st_dv, fb_st_start, fb_st_data} !== {1'b1, i == 0, d[i]})
        $display("FAIL single_beat%0d got=%b/%b/%h exp=1/%b/%h", i, fb_st_dv, fb_st_start, fb_st_data, i == 0, d[i]);
      else n_pass++;
      n_chk++; if ({grant, frame_done} !== (i == 3 ? 3'b001 : 3'b010))
        $display("FAIL single_state%0d got grant=%b done=%b", i, grant, frame_done);
      else n_pass++;
      if (i < 3) begin s0_start = 1'b0; s0_data = d[i+1]; end else s0_dv = 1'b0;
    end
    tick;
    n_chk++; if ({fb_st_dv, frame_done, grant} !== 4'b0) $display("FAIL single_drain got dv=%b done=%b grant=%b exp 0", fb_st_dv, frame_done, grant); else n_pass++;
  endtask

  task automatic test_tie;
    do_reset;
    s0_dv = 1'b1; s0_start = 1'b1; s0_data = 16'ha000;
    s1_dv = 1'b1; s1_start = 1'b1; s1_data = 16'hb000;
    tick;
    n_chk++; if (grant !== 2'b01) $display("FAIL tie_first got=%b exp=01", grant); else n_pass++;
    n_chk++; if ({s0_ready, s1_ready} !== 2'b10) $display("FAIL tie_nonowner_ready got=%b exp=10", {s0_ready, s1_ready}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i < 3) begin s0_start = 1'b0; s0_data = 16'ha001 + 16'(i); end else s0_dv = 1'b0;
    end
    n_chk++; if ({grant, frame_done} !== 3'b001) $display("FAIL tie_src0_done got grant=%b done=%b", grant, frame_done); else n_pass++;
    tick;
    n_chk++; if (grant !== 2'b10) $display("FAIL tie_src1_next got=%b exp=10", grant); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i < 3) begin s1_start = 1'b0; s1_data = 16'hb001 + 16'(i); end else s1_dv = 1'b0;
    end
    n_chk++; if ({grant, frame_done} !== 3'b001) $display("FAIL tie_src1_done got grant=%b done=%b", grant, frame_done); else n_pass++;
    s0_dv = 1'b1; s0_start = 1'b1; s1_dv = 1'b1; s1_start = 1'b1;
    tick;
    n_chk++; if (grant !== 2'b01) $display("FAIL tie_second got=%b exp=01", grant); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [DW:0] sent[$], got[$], prev;
    logic prev_hold, rdy;
    int idx;
    do_reset;
    for (int i = 0; i < 4; i++) sent.push_back({i == 0, DW'($urandom)});
    idx = 0; prev_hold = 1'b0; prev = '0;
    for (int c = 0; c < 16; c++) begin
      fb_st_ready = !(c >= 4 && c < 7);
      s0_dv = idx < 4;
      {s0_start, s0_data} = idx < 4 ? sent[idx] : '0;
      #1;
      rdy = s0_ready;
      if (prev_hold) begin
        n_chk++; if ({fb_st_dv, fb_st_start, fb_st_data} !== {1'b1, prev})
          $display("FAIL bp_stable c=%0d got=%b/%h exp=1/%h", c, fb_st_dv, {fb_st_start, fb_st_data}, prev);
        else n_pass++;
      end
      if (fb_st_dv && !fb_st_ready) begin
        n_chk++; if (s0_ready !== 1'b0) $display("FAIL bp_owner_ready c=%0d got=%b exp=0", c, s0_ready); else n_pass++;
      end
      prev_hold = fb_st_dv && !fb_st_ready;
      prev = {fb_st_start, fb_st_data};
      if (fb_st_dv && fb_st_ready) got.push_back({fb_st_start, fb_st_data});
      tick;
      if (rdy && s0_dv) idx++;
    end
    fb_st_ready = 1'b1;
    n_chk++; if (got.size() !== 4) $display("FAIL bp_count got=%0d exp=4", got.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_chk++; if (got[i] !== sent[i]) $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], sent[i]); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    do_reset;
    s0_dv = 1'b1; s0_start = 1'b1; s0_data = 16'h1234;
    tick;
    tick;
    s0_dv = 1'b0; s0_start = 1'b0;
    s1_dv = 1'b1; s1_start = 1'b1; s1_data = 16'h5678;
    for (int k = 1; k <= 8; k++) begin
      #1;
      n_chk++; if (s1_ready !== 1'b0) $display("FAIL to_nonowner_ready k=%0d got=%b exp=0", k, s1_ready); else n_pass++;
      tick;
      n_chk++; if ({grant, frame_abort} !== (k == 8 ? 3'b001 : 3'b010))
        $display("FAIL to_idle%0d got grant=%b abort=%b", k, grant, frame_abort);
      else n_pass++;
    end
    tick;
    n_chk++; if ({grant, frame_abort} !== 3'b100) $display("FAIL to_regrant got grant=%b abort=%b exp 10/0", grant, frame_abort); else n_pass++;
  endtask

  task automatic test_stray;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      s1_dv = 1'b1; s1_start = 1'b0; s1_data = DW'($urandom);
      #1;
      n_chk++; if ({s1_ready, fb_st_dv, grant} !== 4'b1000)
        $display("FAIL stray%0d got ready=%b dv=%b grant=%b exp 1/0/00", k, s1_ready, fb_st_dv, grant);
      else n_pass++;
      tick;
    end
    s1_dv = 1'b0;
    n_chk++; if (fb_st_dv !== 1'b0) $display("FAIL stray_forwarded got=%b exp=0", fb_st_dv); else n_pass++;
  endtask

  task automatic test_async_reset;
    int idx, got, dn;
    logic rdy;
    do_reset;
    s0_dv = 1'b1; s0_start = 1'b1; s0_data = 16'h0700;
    tick;
    tick;
    s0_start = 1'b0; s0_data = 16'h0701;
    tick;
    #1;
    n_chk++; if ({fb_st_dv, grant} !== 3'b101) $display("FAIL ar_pre got dv=%b grant=%b exp 1/01", fb_st_dv, grant); else n_pass++;
    reset_reset_n = 1'b0;
    #1;
    n_chk++; if ({fb_st_dv, grant} !== 3'b000) $display("FAIL ar_async got dv=%b grant=%b exp 0/00", fb_st_dv, grant); else n_pass++;
    s0_dv = 1'b0;
    tick;
    reset_reset_n = 1'b1;
    idx = 0; got = 0; dn = 0;
    for (int c = 0; c < 12; c++) begin
      s0_dv = idx < 4; s0_start = idx == 0; s0_data = DW'(32'h100 + idx);
      #1;
      rdy = s0_ready;
      if (fb_st_dv) begin
        n_chk++; if ({fb_st_start, fb_st_data} !== {got == 0, DW'(32'h100 + got)})
          $display("FAIL ar_beat%0d got=%b/%h exp=%b/%h", got, fb_st_start, fb_st_data, got == 0, DW'(32'h100 + got));
        else n_pass++;
        got++;
      end
      dn += int'(frame_done);
      tick;
      if (rdy && s0_dv) idx++;
    end
    n_chk++; if (got !== 4 || dn !== 1) $display("FAIL ar_frame got beats=%0d done=%0d exp 4/1", got, dn); else n_pass++;
  endtask

  task automatic test_random;
    int own, cnt, idle, p0, p1;
    int probs[3] = '{5, 50, 95};
    bit last, mdv, mst, mdone, mabort, acc, slot, r0, r1, req0, req1;
    logic [DW-1:0] mdata;
    logic [1:0] eg;
    do_reset;
    own = -1; cnt = 0; idle = 0; last = 1'b1; mdv = 1'b0; mst = 1'b0; mdata = '0; mdone = 1'b0; mabort = 1'b0;
    p0 = 50; p1 = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin p0 = probs[$urandom_range(2)]; p1 = probs[$urandom_range(2)]; end
      s0_dv = $urandom_range(99) < p0; s0_start = $urandom_range(4) == 0; s0_data = DW'($urandom);
      s1_dv = $urandom_range(99) < p1; s1_start = $urandom_range(4) == 0; s1_data = DW'($urandom);
      fb_st_ready = $urandom_range(3) != 0;
      #1;
      slot = !mdv || fb_st_ready;
      req0 = s0_dv && s0_start; req1 = s1_dv && s1_start;
      r0 = own < 0 ? s0_dv && !s0_start : own == 0 && slot;
      r1 = own < 0 ? s1_dv && !s1_start : own == 1 && slot;
      acc = own == 0 ? s0_dv && slot : own == 1 ? s1_dv && slot : 1'b0;
      eg = own == 0 ? 2'b01 : own == 1 ? 2'b10 : 2'b00;
      n_chk++; if ({s0_ready, s1_ready} !== {r0, r1}) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {s0_ready, s1_ready}, {r0, r1}); else n_pass++;
      n_chk++; if ({grant, fb_st_dv, frame_done, frame_abort} !== {eg, mdv, mdone, mabort})
        $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, {grant, fb_st_dv, frame_done, frame_abort}, {eg, mdv, mdone, mabort});
      else n_pass++;
      if (mdv) begin
        n_chk++; if ({fb_st_start, fb_st_data} !== {mst, mdata})
          $display("FAIL rnd_data c=%0d got=%b/%h exp=%b/%h", c, fb_st_start, fb_st_data, mst, mdata);
        else n_pass++;
      end
      mdone = 1'b0; mabort = 1'b0;
      if (acc) begin
        mdv = 1'b1;
        mst = own == 0 ? s0_start : s1_start;
        mdata = own == 0 ? s0_data : s1_data;
      end else if (fb_st_ready) mdv = 1'b0;
      if (own < 0) begin
        if (req0 && req1) own = last ? 0 : 1;
        else if (req0) own = 0;
        else if (req1) own = 1;
        cnt = 0; idle = 0;
      end else if (acc) begin
        idle = 0;
        cnt = mst ? 1 : cnt + 1;
        if (cnt == FP) begin last = own == 1; own = -1; cnt = 0; mdone = 1'b1; end
      end else begin
        idle++;
        if (idle == TO) begin last = own == 1; own = -1; cnt = 0; idle = 0; mabort = 1'b1; end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_tie;
    test_backpressure;
    test_timeout;
    test_stray;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
